// File: rtl/poly_note_pkg.sv
// Shared types, widths and ROM content functions for the polyphonic note player.
// Pitch steps assume a 48 kHz sample rate and a 22-bit phase accumulator.
package poly_note_pkg;

    localparam int NOTE_W      = 6;
    localparam int DUR_W       = 6;
    localparam int STEP_W      = 20;
    localparam int PHASE_W     = 22;
    localparam int SINE_ADDR_W = 10;
    localparam int SINE_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FREQ,
        ST_PHASE,
        ST_SINE,
        ST_ACC,
        ST_OUT
    } seq_state_e;

    // Note 1 is A1 (55 Hz); every 12 notes doubles the step of the base octave.
    function automatic logic [STEP_W-1:0] note_step(input logic [NOTE_W-1:0] note);
        logic [NOTE_W-1:0] k;
        logic [2:0]        oct;
        logic [3:0]        semi;
        logic [STEP_W-1:0] base;
        k    = note - 6'd1;
        oct  = 3'(k / 6'd12);
        semi = 4'(k % 6'd12);
        case (semi)
            4'd0:    base = 20'd4806;
            4'd1:    base = 20'd5092;
            4'd2:    base = 20'd5395;
            4'd3:    base = 20'd5716;
            4'd4:    base = 20'd6055;
            4'd5:    base = 20'd6415;
            4'd6:    base = 20'd6797;
            4'd7:    base = 20'd7201;
            4'd8:    base = 20'd7629;
            4'd9:    base = 20'd8083;
            4'd10:   base = 20'd8563;
            default: base = 20'd9073;
        endcase
        note_step = (note == '0) ? '0 : (base << oct);
    endfunction

    // Parabolic half-wave per address half; bit 9 selects the negative half.
    function automatic logic [SINE_W-1:0] sine_value(input logic [SINE_ADDR_W-1:0] addr);
        logic [8:0]  x;
        logic [17:0] prod;
        logic [15:0] mag;
        x    = addr[8:0];
        prod = {9'd0, x} * {9'd0, 9'd511 - x};
        mag  = prod[16:1];
        sine_value = addr[9] ? (~mag + 16'd1) : mag;
    endfunction

endpackage

// File: rtl/poly_note_player_rom.sv
// Shared registered lookup tables: note-to-phase-step and phase-to-sine.
module frequency_rom
    import poly_note_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NOTE_W-1:0] note,
    output logic [STEP_W-1:0] step
);

    logic [STEP_W-1:0] step_d;
    logic [STEP_W-1:0] step_q;

    always_comb begin
        step_d = note_step(note);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= '0;
        end else begin
            step_q <= step_d;
        end
    end

    assign step = step_q;

endmodule

module sine_rom
    import poly_note_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SINE_ADDR_W-1:0] addr,
    output logic [SINE_W-1:0]      value
);

    logic [SINE_W-1:0] value_d;
    logic [SINE_W-1:0] value_q;

    always_comb begin
        value_d = sine_value(addr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/poly_note_player_voice_slot.sv
// One voice: note, remaining beats, active flag and phase accumulator.
module voice_slot
    import poly_note_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [NOTE_W-1:0]      load_note,
    input  logic [DUR_W-1:0]       load_dur,
    input  logic                   beat_en,
    input  logic                   step_en,
    input  logic [STEP_W-1:0]      step,
    output logic [NOTE_W-1:0]      note,
    output logic                   active,
    output logic                   sounding,
    output logic                   done,
    output logic [SINE_ADDR_W-1:0] sine_addr
);

    logic [NOTE_W-1:0]  note_d,   note_q;
    logic [DUR_W-1:0]   rem_d,    rem_q;
    logic               active_d, active_q;
    logic [PHASE_W-1:0] phase_d,  phase_q;
    logic               done_d,   done_q;
    logic [PHASE_W-1:0] phase_adv;

    assign sounding  = active_q && (note_q != '0);
    assign phase_adv = sounding ? (phase_q + {{(PHASE_W-STEP_W){1'b0}}, step}) : phase_q;

    // A load takes priority over a coincident beat: no decrement, no done pulse.
    always_comb begin
        note_d   = note_q;
        rem_d    = rem_q;
        active_d = active_q;
        phase_d  = phase_q;
        done_d   = 1'b0;
        if (load) begin
            note_d   = load_note;
            rem_d    = load_dur;
            active_d = 1'b1;
            phase_d  = '0;
        end else begin
            if (beat_en && active_q) begin
                if (rem_q == 6'd1) begin
                    rem_d    = '0;
                    active_d = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    rem_d = rem_q - 6'd1;
                end
            end
            if (step_en) begin
                phase_d = phase_adv;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_q   <= '0;
            rem_q    <= '0;
            active_q <= 1'b0;
            phase_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            note_q   <= note_d;
            rem_q    <= rem_d;
            active_q <= active_d;
            phase_q  <= phase_d;
            done_q   <= done_d;
        end
    end

    assign note      = note_q;
    assign active    = active_q;
    assign done      = done_q;
    assign sine_addr = phase_adv[PHASE_W-1 -: SINE_ADDR_W];

endmodule

// File: rtl/poly_note_player.sv
// Polyphonic note player: per-voice duration/phase state, a time-multiplexed
// sequencer sharing one frequency ROM and one sine ROM, and a mixer.
module poly_note_player
    import poly_note_pkg::*;
#(
    parameter int VOICES   = 4,
    parameter int SAMPLE_W = 16,
    parameter int MIX_MODE = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       play_enable,
    input  logic                       load_new_note,
    input  logic [$clog2(VOICES)-1:0]  load_voice,
    input  logic [5:0]                 note_to_load,
    input  logic [5:0]                 duration_to_load,
    input  logic                       beat,
    input  logic                       generate_next_sample,
    output logic [SAMPLE_W-1:0]        sample_out,
    output logic                       new_sample_ready,
    output logic [VOICES-1:0]          voice_active,
    output logic [VOICES-1:0]          done_with_note
);

    localparam int IDX_W = $clog2(VOICES);
    localparam int ACC_W = SAMPLE_W + IDX_W;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(IDX_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(IDX_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    seq_state_e                 state_d, state_q;
    logic [IDX_W-1:0]           idx_d, idx_q;
    logic signed [ACC_W-1:0]    acc_d, acc_q;
    logic [SAMPLE_W-1:0]        sample_d, sample_q;
    logic                       ready_d, ready_q;
    logic [SINE_ADDR_W-1:0]     sine_addr_d, sine_addr_q;

    logic [NOTE_W-1:0]          v_note      [VOICES];
    logic [SINE_ADDR_W-1:0]     v_sine_addr [VOICES];
    logic [VOICES-1:0]          v_active;
    logic [VOICES-1:0]          v_sounding;
    logic [VOICES-1:0]          v_done;
    logic [VOICES-1:0]          v_load;
    logic [VOICES-1:0]          v_step_en;

    logic [NOTE_W-1:0]          cur_note;
    logic [STEP_W-1:0]          freq_step;
    logic [SINE_W-1:0]          sine_raw;
    logic signed [SAMPLE_W-1:0] sine_s;
    logic signed [ACC_W-1:0]    sine_ext;
    logic signed [ACC_W-1:0]    shifted;
    logic [SAMPLE_W-1:0]        mixed;
    logic                       beat_en;

    assign beat_en = beat && play_enable;

    for (genvar g = 0; g < VOICES; g++) begin : g_voice
        assign v_load[g]    = load_new_note && (duration_to_load != '0) && (load_voice == IDX_W'(g));
        assign v_step_en[g] = play_enable && (state_q == ST_PHASE) && (idx_q == IDX_W'(g));

        voice_slot u_voice (
            .clk       (clk),
            .rst_n     (reset),
            .load      (v_load[g]),
            .load_note (note_to_load),
            .load_dur  (duration_to_load),
            .beat_en   (beat_en),
            .step_en   (v_step_en[g]),
            .step      (freq_step),
            .note      (v_note[g]),
            .active    (v_active[g]),
            .sounding  (v_sounding[g]),
            .done      (v_done[g]),
            .sine_addr (v_sine_addr[g])
        );
    end

    assign cur_note = v_note[idx_q];

    frequency_rom u_freq_rom (
        .clk   (clk),
        .rst_n (reset),
        .note  (cur_note),
        .step  (freq_step)
    );

    sine_rom u_sine_rom (
        .clk   (clk),
        .rst_n (reset),
        .addr  (sine_addr_q),
        .value (sine_raw)
    );

    // The ROM is 16 bits wide; align its MSB to the sample MSB.
    if (SAMPLE_W > SINE_W) begin : g_widen
        assign sine_s = {sine_raw, {(SAMPLE_W-SINE_W){1'b0}}};
    end else begin : g_narrow
        assign sine_s = sine_raw[SINE_W-1 -: SAMPLE_W];
    end

    assign sine_ext = {{IDX_W{sine_s[SAMPLE_W-1]}}, sine_s};
    assign shifted  = acc_q >>> IDX_W;

    always_comb begin
        mixed = shifted[SAMPLE_W-1:0];
        if (MIX_MODE != 0) begin
            if (acc_q > SAT_MAX) begin
                mixed = SAT_MAX[SAMPLE_W-1:0];
            end else if (acc_q < SAT_MIN) begin
                mixed = SAT_MIN[SAMPLE_W-1:0];
            end else begin
                mixed = acc_q[SAMPLE_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        sample_d    = sample_q;
        ready_d     = 1'b0;
        sine_addr_d = sine_addr_q;
        if (play_enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (generate_next_sample) begin
                        acc_d   = '0;
                        idx_d   = '0;
                        state_d = ST_FREQ;
                    end
                end
                ST_FREQ: begin
                    state_d = ST_PHASE;
                end
                ST_PHASE: begin
                    sine_addr_d = v_sine_addr[idx_q];
                    state_d     = ST_SINE;
                end
                ST_SINE: begin
                    state_d = ST_ACC;
                end
                ST_ACC: begin
                    acc_d = acc_q + (v_sounding[idx_q] ? sine_ext : '0);
                    if (idx_q == IDX_W'(VOICES-1)) begin
                        state_d = ST_OUT;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_FREQ;
                    end
                end
                ST_OUT: begin
                    sample_d = mixed;
                    ready_d  = 1'b1;
                    state_d  = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            sample_q    <= '0;
            ready_q     <= 1'b0;
            sine_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            sample_q    <= sample_d;
            ready_q     <= ready_d;
            sine_addr_q <= sine_addr_d;
        end
    end

    assign sample_out       = sample_q;
    assign new_sample_ready = ready_q;
    assign voice_active     = v_active;
    assign done_with_note   = v_done;

endmodule

// File: tb/tb_poly_note_player.sv
// Directed bench for poly_note_player; two instances differ only in MIX_MODE.
module tb_poly_note_player;

    logic        clk;
    logic        reset;
    logic        play_enable;
    logic        load_new_note;
    logic [1:0]  load_voice;
    logic [5:0]  note_to_load;
    logic [5:0]  duration_to_load;
    logic        beat;
    logic        generate_next_sample;
    logic [15:0] s0, s1;
    logic        rdy0, rdy1;
    logic [3:0]  act0, act1;
    logic [3:0]  done0, done1;

    int vec_cnt;
    int err_cnt;

    poly_note_player #(.VOICES(4), .SAMPLE_W(16), .MIX_MODE(0)) u_dut0 (
        .clk                  (clk),
        .reset                (reset),
        .play_enable          (play_enable),
        .load_new_note        (load_new_note),
        .load_voice           (load_voice),
        .note_to_load         (note_to_load),
        .duration_to_load     (duration_to_load),
        .beat                 (beat),
        .generate_next_sample (generate_next_sample),
        .sample_out           (s0),
        .new_sample_ready     (rdy0),
        .voice_active         (act0),
        .done_with_note       (done0)
    );

    poly_note_player #(.VOICES(4), .SAMPLE_W(16), .MIX_MODE(1)) u_dut1 (
        .clk                  (clk),
        .reset                (reset),
        .play_enable          (play_enable),
        .load_new_note        (load_new_note),
        .load_voice           (load_voice),
        .note_to_load         (note_to_load),
        .duration_to_load     (duration_to_load),
        .beat                 (beat),
        .generate_next_sample (generate_next_sample),
        .sample_out           (s1),
        .new_sample_ready     (rdy1),
        .voice_active         (act1),
        .done_with_note       (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_load(input logic [1:0] v, input logic [5:0] n, input logic [5:0] d);
        @(negedge clk);
        load_new_note    = 1'b1;
        load_voice       = v;
        note_to_load     = n;
        duration_to_load = d;
        @(negedge clk);
        load_new_note    = 1'b0;
    endtask

    task automatic pulse_beat();
        @(negedge clk);
        beat = 1'b1;
        @(negedge clk);
        beat = 1'b0;
    endtask

    // Latency in edges after the accepting edge; 40 means no pulse seen.
    task automatic do_request(output int lat);
        @(negedge clk);
        generate_next_sample = 1'b1;
        @(negedge clk);
        generate_next_sample = 1'b0;
        lat = 0;
        while (!rdy0 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if ({s1, s0} !== 32'h0) begin
            err_cnt++;
            $display("FAIL reset_sample: got %h/%h expected 0/0", s0, s1);
        end
        vec_cnt++;
        if ({rdy1, rdy0, act1, act0, done1, done0} !== 18'h0) begin
            err_cnt++;
            $display("FAIL reset_flags: got rdy=%b%b act=%h/%h done=%h/%h expected all 0",
                     rdy0, rdy1, act0, act1, done0, done1);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle_request();
        int lat;
        do_request(lat);
        vec_cnt++;
        if (lat !== 17) begin
            err_cnt++;
            $display("FAIL idle_latency: got %0d expected 17", lat);
        end
        vec_cnt++;
        if ({rdy1, s1, s0} !== 33'h1_0000_0000) begin
            err_cnt++;
            $display("FAIL idle_sample: got rdy1=%b s=%h/%h expected 1 0000/0000", rdy1, s0, s1);
        end
        @(negedge clk);
        vec_cnt++;
        if (rdy0 !== 1'b0) begin
            err_cnt++;
            $display("FAIL idle_pulse_width: got %b expected 0", rdy0);
        end
    endtask

    task automatic test_beat_countdown();
        do_load(2'd2, 6'd30, 6'd3);
        vec_cnt++;
        if ({act0, done0} !== 8'h40) begin
            err_cnt++;
            $display("FAIL count_load: got act=%b done=%b expected 0100 0000", act0, done0);
        end
        for (int b = 1; b <= 3; b++) begin
            pulse_beat();
            vec_cnt++;
            if (b < 3 && {act0, done0} !== 8'h40) begin
                err_cnt++;
                $display("FAIL count_beat%0d: got act=%b done=%b expected 0100 0000", b, act0, done0);
            end else if (b == 3 && {act0, done0} !== 8'h04) begin
                err_cnt++;
                $display("FAIL count_end: got act=%b done=%b expected 0000 0100", act0, done0);
            end
        end
        @(negedge clk);
        vec_cnt++;
        if (done0 !== 4'b0000) begin
            err_cnt++;
            $display("FAIL count_done_width: got %b expected 0000", done0);
        end
        do_load(2'd3, 6'd5, 6'd0);
        vec_cnt++;
        if (act0 !== 4'b0000) begin
            err_cnt++;
            $display("FAIL zero_dur_load: got %b expected 0000", act0);
        end
    endtask

    task automatic test_load_beat_collision();
        do_load(2'd0, 6'd7, 6'd1);
        do_load(2'd1, 6'd9, 6'd1);
        @(negedge clk);
        load_new_note    = 1'b1;
        load_voice       = 2'd1;
        note_to_load     = 6'd9;
        duration_to_load = 6'd5;
        beat             = 1'b1;
        @(negedge clk);
        load_new_note    = 1'b0;
        beat             = 1'b0;
        vec_cnt++;
        if ({act0, done0} !== 8'h21) begin
            err_cnt++;
            $display("FAIL collide: got act=%b done=%b expected 0010 0001", act0, done0);
        end
    endtask

    task automatic test_freeze();
        int lat;
        logic seen;
        logic [3:0] exp_done;
        play_enable = 1'b0;
        do_request(lat);
        vec_cnt++;
        if (lat !== 40) begin
            err_cnt++;
            $display("FAIL freeze_request: got latency %0d expected none (40)", lat);
        end
        pulse_beat();
        vec_cnt++;
        if ({act0, done0} !== 8'h20) begin
            err_cnt++;
            $display("FAIL freeze_beat: got act=%b done=%b expected 0010 0000", act0, done0);
        end
        do_load(2'd3, 6'd5, 6'd2);
        vec_cnt++;
        if (act0 !== 4'b1010) begin
            err_cnt++;
            $display("FAIL freeze_load: got %b expected 1010", act0);
        end
        play_enable = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rdy0) seen = 1'b1;
        end
        vec_cnt++;
        if (seen !== 1'b0) begin
            err_cnt++;
            $display("FAIL freeze_dropped: got ready %b expected 0", seen);
        end
        // voice 3 has 2 beats left; voice 1 still holds 5 despite the frozen beat
        for (int b = 1; b <= 5; b++) begin
            pulse_beat();
            exp_done = (b == 2) ? 4'b1000 : (b == 5) ? 4'b0010 : 4'b0000;
            vec_cnt++;
            if (done0 !== exp_done) begin
                err_cnt++;
                $display("FAIL freeze_countdown beat%0d: got %b expected %b", b, done0, exp_done);
            end
        end
    endtask

    task automatic test_single_voice();
        int lat;
        do_load(2'd0, 6'd63, 6'd63);
        do_load(2'd1, 6'd0, 6'd63);
        do_request(lat);
        vec_cnt++;
        if (lat !== 17 || s0 !== 16'd2462 || s1 !== 16'd9849) begin
            err_cnt++;
            $display("FAIL single_req1: got lat=%0d s=%0d/%0d expected 17 2462/9849", lat, s0, s1);
        end
        do_request(lat);
        vec_cnt++;
        if (lat !== 17 || s0 !== 16'd4483 || s1 !== 16'd17934) begin
            err_cnt++;
            $display("FAIL single_req2: got lat=%0d s=%0d/%0d expected 17 4483/17934", lat, s0, s1);
        end
        vec_cnt++;
        if (act0 !== 4'b0011) begin
            err_cnt++;
            $display("FAIL single_active: got %b expected 0011", act0);
        end
    endtask

    task automatic test_mix_saturation();
        int lat;
        logic [15:0] exp_neg;
        exp_neg = -16'sd8330;
        for (int v = 0; v < 4; v++) begin
            do_load(2'(v), 6'd63, 6'd63);
        end
        do_request(lat);
        vec_cnt++;
        if (lat !== 17 || s0 !== 16'd9849 || s1 !== 16'h7FFF) begin
            err_cnt++;
            $display("FAIL mix_req1: got lat=%0d s=%h/%h expected 17 2679/7fff", lat, s0, s1);
        end
        play_enable = 1'b0;
        do_request(lat);
        play_enable = 1'b1;
        do_request(lat);
        vec_cnt++;
        if (lat !== 17 || s0 !== 16'd17934 || s1 !== 16'h7FFF) begin
            err_cnt++;
            $display("FAIL mix_req2: got lat=%0d s=%h/%h expected 17 460e/7fff", lat, s0, s1);
        end
        for (int r = 3; r <= 13; r++) begin
            do_request(lat);
        end
        vec_cnt++;
        if (lat !== 17 || s0 !== exp_neg || s1 !== 16'h8000) begin
            err_cnt++;
            $display("FAIL mix_req13: got lat=%0d s=%h/%h expected 17 %h/8000", lat, s0, s1, exp_neg);
        end
        repeat (10) @(negedge clk);
        vec_cnt++;
        if (s0 !== exp_neg || s1 !== 16'h8000) begin
            err_cnt++;
            $display("FAIL mix_hold: got %h/%h expected %h/8000", s0, s1, exp_neg);
        end
    endtask

    task automatic test_reset_mid_sequence();
        logic seen;
        @(negedge clk);
        generate_next_sample = 1'b1;
        @(negedge clk);
        generate_next_sample = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        vec_cnt++;
        if ({s1, s0, rdy1, rdy0, act1, act0, done1, done0} !== 50'h0) begin
            err_cnt++;
            $display("FAIL midreset_outputs: got s=%h/%h rdy=%b%b act=%h/%h done=%h/%h expected all 0",
                     s0, s1, rdy0, rdy1, act0, act1, done0, done1);
        end
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rdy0 || rdy1) seen = 1'b1;
        end
        vec_cnt++;
        if (seen !== 1'b0 || act0 !== 4'b0000) begin
            err_cnt++;
            $display("FAIL midreset_abort: got ready_seen=%b act=%b expected 0 0000", seen, act0);
        end
    endtask

    initial begin
        vec_cnt              = 0;
        err_cnt              = 0;
        reset                = 1'b0;
        play_enable          = 1'b1;
        load_new_note        = 1'b0;
        load_voice           = '0;
        note_to_load         = '0;
        duration_to_load     = '0;
        beat                 = 1'b0;
        generate_next_sample = 1'b0;

        test_reset();
        test_idle_request();
        test_beat_countdown();
        test_load_beat_collision();
        test_freeze();
        apply_reset();
        test_single_voice();
        apply_reset();
        test_mix_saturation();
        test_reset_mid_sequence();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/poly_note_player.md
POLY_NOTE_PLAYER -- requirements
Module: poly_note_player

Interface
REQ-001 SHALL have parameter VOICES, default 4, number of independent voices (power of 2, 2..8).
REQ-002 SHALL have parameter SAMPLE_W, default 16, signed sample width.
REQ-003 SHALL have parameter MIX_MODE, default 0, where 0 = scale sum by 1/VOICES and 1 = saturate sum to SAMPLE_W.
REQ-004 SHALL have port clk, input, 1 bit, the single system clock; all state is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port play_enable, input, 1 bit; high = play, low = freeze.
REQ-007 SHALL have ports load_new_note (input, 1, load strobe), load_voice (input, clog2(VOICES), target voice), note_to_load (input, 6, note; 0 = rest) and duration_to_load (input, 6, beats).
REQ-008 SHALL have port beat, input, 1 bit, single-cycle 1/48 s tick.
REQ-009 SHALL have port generate_next_sample, input, 1 bit, codec sample request pulse.
REQ-010 SHALL have ports sample_out (output, SAMPLE_W, mixed signed sample) and new_sample_ready (output, 1, one-cycle valid pulse).
REQ-011 SHALL have ports voice_active (output, VOICES, per-voice busy flag) and done_with_note (output, VOICES, per-voice one-cycle end pulse).

Function
REQ-012 Per-voice state SHALL be: note (6b), remaining beats (6b), active flag, phase accumulator (22b).
REQ-013 A load with duration_to_load != 0 SHALL, on the next edge, set the selected voice's note and remaining to the inputs, set active=1 and clear its phase; loading a busy voice retriggers it.
REQ-014 A load with duration_to_load == 0 SHALL leave the voice unchanged.
REQ-015 On beat with play_enable=1, each active voice SHALL decrement remaining; a voice at remaining==1 SHALL go to active=0 and remaining=0 and pulse its done_with_note bit for exactly one cycle.
REQ-016 A load and a beat on the same voice in the same cycle SHALL apply the load only, with no decrement and no done pulse; other voices still see the beat.
REQ-017 With play_enable=0, durations, phases and the sequencer SHALL be frozen, requests SHALL be ignored and loads SHALL still be accepted.
REQ-018 The sequencer FSM SHALL have states IDLE, FREQ, PHASE, SINE, ACC and OUT, with a voice index i.
REQ-019 In IDLE, generate_next_sample with play_enable=1 SHALL clear the accumulator, set i=0 and go to FREQ; requests received outside IDLE SHALL be dropped.
REQ-020 FREQ SHALL present note[i] to the shared frequency_rom (1-cycle latency) and go to PHASE.
REQ-021 PHASE SHALL, if voice i is active and its note != 0, add the 20-bit step to phase[i] modulo 2^22; it SHALL present phase[i][21:12] (post-update) to the shared sine_rom and go to SINE.
REQ-022 SINE SHALL wait for the 1-cycle sine_rom latency and go to ACC.
REQ-023 ACC SHALL add the sign-extended sine value, or 0 if voice i is inactive or a rest, into a SAMPLE_W+clog2(VOICES) accumulator; it SHALL go to FREQ with i+1 if i<VOICES-1, else to OUT.
REQ-024 OUT SHALL register the mixed result to sample_out, pulse new_sample_ready, and return to IDLE.
REQ-025 new_sample_ready SHALL assert exactly 4*VOICES+1 cycles after the accepted request edge.
REQ-026 Mix with MIX_MODE=0 SHALL be an arithmetic shift right of the accumulator by clog2(VOICES).
REQ-027 Mix with MIX_MODE=1 SHALL clamp the accumulator to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
REQ-028 sample_out SHALL hold its value between OUT states.

Reset
REQ-029 reset low SHALL asynchronously clear all voice state, set FSM=IDLE, and drive sample_out=0, new_sample_ready=0, voice_active=0 and done_with_note=0.
REQ-030 Reset mid-sequence SHALL abort the sequence with no new_sample_ready pulse after release.

Structure
REQ-031 Package poly_note_pkg SHALL hold the FSM state enum, NOTE_W=6, DUR_W=6, STEP_W=20, PHASE_W=22 and SINE_ADDR_W=10.
REQ-032 Sub-module voice_slot, instantiated VOICES times, SHALL own one voice's note, duration, active and phase registers; frequency_rom and sine_rom SHALL be shared, one instance each.

Verification
REQ-033 Scenario: VOICES=4, load voice 2 with note 30 and duration 3, then 3 beats -> voice_active[2] high for 3 beats and done_with_note=4'b0100 for one cycle on the 3rd beat.
REQ-034 Scenario: single request, no voices active -> new_sample_ready pulse at cycle 17 with sample_out=0.
REQ-035 Scenario: all 4 voices set to the same note, MIX_MODE=0 -> sample_out equals the single-voice sine value; MIX_MODE=1 -> saturates at 16'h7FFF near the sine peak.
REQ-036 Scenario: load and beat on voice 1 in the same cycle with remaining=1 -> no done pulse and remaining equals the new duration.
REQ-037 Scenario: play_enable=0 with a request and a beat -> no new_sample_ready, remaining unchanged and phases unchanged.
REQ-038 Scenario: reset asserted during the SINE state -> all outputs 0 immediately and no pulse after release.
